// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data bus arbiter: bus widths,
// enable levels, FSM state encoding and the default abort timeout.
package mem_arbiter_pkg;

  localparam int unsigned REG_BUS_W       = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam logic [SEL_W-1:0] SEL_WORD = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY_IF  = 3'd1,
    ST_BUSY_MEM = 3'd2,
    ST_DONE_IF  = 3'd3,
    ST_DONE_MEM = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [REG_BUS_W-1:0] addr;
    logic [REG_BUS_W-1:0] data;
    logic [SEL_W-1:0]     sel;
    logic                 we;
  } bus_req_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_req_t fetch_req(input logic [REG_BUS_W-1:0] addr);
    bus_req_t r;
    r.addr = addr;
    r.data = '0;
    r.sel  = SEL_WORD;
    r.we   = 1'b0;
    return r;
  endfunction

  function automatic logic is_busy(input arb_state_e s);
    return (s == ST_BUSY_IF) || (s == ST_BUSY_MEM);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request ports and shared-bus ports of the arbiter.
// The arbiter takes the master modport (it masters the shared bus); the environment takes slave.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                 if_ce_i;
  logic [REG_BUS_W-1:0] if_addr_i;
  logic                 if_stall_i;
  logic [REG_BUS_W-1:0] if_data_o;
  logic                 if_stallreq_o;

  logic                 mem_ce_i;
  logic                 mem_we_i;
  logic [REG_BUS_W-1:0] mem_addr_i;
  logic [SEL_W-1:0]     mem_sel_i;
  logic [REG_BUS_W-1:0] mem_data_i;
  logic                 mem_stall_i;
  logic [REG_BUS_W-1:0] mem_data_o;
  logic                 mem_stallreq_o;

  logic [REG_BUS_W-1:0] bus_addr_o;
  logic [REG_BUS_W-1:0] bus_data_o;
  logic [SEL_W-1:0]     bus_sel_o;
  logic                 bus_we_o;
  logic                 bus_stb_o;
  logic [REG_BUS_W-1:0] bus_data_i;
  logic                 bus_ack_i;
  logic                 bus_err_o;

  modport master (
    input  if_ce_i, if_addr_i, if_stall_i,
    output if_data_o, if_stallreq_o,
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, mem_stall_i,
    output mem_data_o, mem_stallreq_o,
    output bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_stb_o, bus_err_o,
    input  bus_data_i, bus_ack_i
  );

  modport slave (
    output if_ce_i, if_addr_i, if_stall_i,
    input  if_data_o, if_stallreq_o,
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, mem_stall_i,
    input  mem_data_o, mem_stallreq_o,
    input  bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_stb_o, bus_err_o,
    output bus_data_i, bus_ack_i
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one shared bus; min latency: request edge N, strobe N+1, DONE N+2.
// Backpressure: stallreq holds a port until its DONE; DONE is held while that stage is stalled.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter bit          MEM_FIRST   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master arb
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  bus_req_t             req_q, req_d;
  logic                 stb_q, stb_d;
  logic [REG_BUS_W-1:0] if_data_q, if_data_d;
  logic [REG_BUS_W-1:0] mem_data_q, mem_data_d;

  bus_req_t mem_req;
  logic     if_req;
  logic     mem_req_vld;
  logic     grant_mem;
  logic     grant_if;
  logic     timeout_abort;

  always_comb begin
    mem_req      = '0;
    mem_req.addr = arb.mem_addr_i;
    mem_req.data = arb.mem_data_i;
    mem_req.sel  = arb.mem_sel_i;
    mem_req.we   = (arb.mem_we_i == WRITE_ENABLE);
  end

  assign if_req      = (arb.if_ce_i == CHIP_ENABLE);
  assign mem_req_vld = (arb.mem_ce_i == CHIP_ENABLE);
  assign grant_mem   = mem_req_vld && (MEM_FIRST || !if_req);
  assign grant_if    = if_req && !grant_mem;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    stb_d         = stb_q;
    if_data_d     = if_data_q;
    mem_data_d    = mem_data_q;
    timeout_abort = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (grant_mem) begin
          state_d = ST_BUSY_MEM;
          req_d   = mem_req;
          stb_d   = 1'b1;
          cnt_d   = CNT_ONE;
        end else if (grant_if) begin
          state_d = ST_BUSY_IF;
          req_d   = fetch_req(arb.if_addr_i);
          stb_d   = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end

      // cnt_q holds the 1-based index of the current busy cycle; an ack in
      // the final allowed cycle still wins over the abort.
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (arb.bus_ack_i) begin
          stb_d    = 1'b0;
          req_d.we = 1'b0;
          if (state_q == ST_BUSY_MEM) begin
            mem_data_d = arb.bus_data_i;
            state_d    = ST_DONE_MEM;
          end else begin
            if_data_d = arb.bus_data_i;
            state_d   = ST_DONE_IF;
          end
        end else if (cnt_q >= CNT_LIMIT) begin
          timeout_abort = 1'b1;
          stb_d         = 1'b0;
          req_d.we      = 1'b0;
          if (state_q == ST_BUSY_MEM) begin
            mem_data_d = '0;
            state_d    = ST_DONE_MEM;
          end else begin
            if_data_d = '0;
            state_d   = ST_DONE_IF;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE_IF: begin
        if (!arb.if_stall_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE_MEM: begin
        if (!arb.mem_stall_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      stb_q      <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      stb_q      <= stb_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign arb.bus_addr_o = req_q.addr;
  assign arb.bus_data_o = req_q.data;
  assign arb.bus_sel_o  = req_q.sel;
  assign arb.bus_we_o   = req_q.we;
  assign arb.bus_stb_o  = stb_q;
  assign arb.bus_err_o  = timeout_abort && (rst != RST_ENABLE);

  assign arb.if_data_o  = if_data_q;
  assign arb.mem_data_o = mem_data_q;

  // A port whose ce drops mid-access sees no stall; its result is simply discarded.
  assign arb.if_stallreq_o  = if_req && (state_q != ST_DONE_IF);
  assign arb.mem_stallreq_o = mem_req_vld && (state_q != ST_DONE_MEM);

  a_stb_only_busy: assert property (@(posedge clk) disable iff (rst)
    stb_q |-> is_busy(state_q));

  a_err_only_busy: assert property (@(posedge clk) disable iff (rst)
    timeout_abort |-> is_busy(state_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single accesses plus
// hand sequences for priority, reset mid-access and timeout, with a per-port result scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TO = 4;
  localparam logic [31:0] GARBAGE = 32'h0BAD_0BAD;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if ifc ();

  mem_arbiter #(
    .TIMEOUT_CYC(TO),
    .MEM_FIRST  (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(ifc.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          ack_k;      // busy cycle carrying the ack; 0 = never ack
    logic [31:0] rdata;
    int          stall_cyc;  // cycles the owning stage stays stalled in DONE
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  int checks   = 0;
  int failures = 0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic        prev_if_sr  = 1'b0;
  logic        prev_mem_sr = 1'b0;
  logic [31:0] if_model    = '0;
  logic [31:0] mem_model   = '0;

  function automatic vec_t mk(input bit is_mem, input bit we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata, input int ack_k,
                              input logic [31:0] rdata, input int stall_cyc,
                              input logic [31:0] exp_data, input bit exp_err);
    vec_t v;
    v.is_mem = is_mem; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.ack_k = ack_k; v.rdata = rdata; v.stall_cyc = stall_cyc;
    v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // Scoreboard: a falling stallreq with ce still high marks a port entering DONE.
  task automatic sb_sample();
    if (ifc.if_ce_i && !ifc.if_stallreq_o && prev_if_sr) begin
      if (if_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_if_unexpected_done: actual=0x%08h required=none", ifc.if_data_o);
      end else begin
        chk32("sb_if_data", ifc.if_data_o, if_q.pop_front());
      end
    end
    if (ifc.mem_ce_i && !ifc.mem_stallreq_o && prev_mem_sr) begin
      if (mem_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_mem_unexpected_done: actual=0x%08h required=none", ifc.mem_data_o);
      end else begin
        chk32("sb_mem_data", ifc.mem_data_o, mem_q.pop_front());
      end
    end
    prev_if_sr  = ifc.if_stallreq_o;
    prev_mem_sr = ifc.mem_stallreq_o;
  endtask

  task automatic neg();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sr_of(input bit is_mem);
    return is_mem ? ifc.mem_stallreq_o : ifc.if_stallreq_o;
  endfunction

  function automatic logic [31:0] data_of(input bit is_mem);
    return is_mem ? ifc.mem_data_o : ifc.if_data_o;
  endfunction

  task automatic set_stall(input bit is_mem, input logic s);
    if (is_mem) ifc.mem_stall_i = s;
    else        ifc.if_stall_i  = s;
  endtask

  task automatic clear_inputs();
    ifc.if_ce_i = 1'b0;  ifc.if_addr_i = '0;  ifc.if_stall_i = 1'b0;
    ifc.mem_ce_i = 1'b0; ifc.mem_we_i = 1'b0; ifc.mem_addr_i = '0;
    ifc.mem_sel_i = '0;  ifc.mem_data_i = '0; ifc.mem_stall_i = 1'b0;
    ifc.bus_data_i = GARBAGE; ifc.bus_ack_i = 1'b0;
  endtask

  // Starts at posedge+1 with the arbiter idle; returns at posedge+1 idle again.
  task automatic do_access(input int idx, input vec_t v);
    string       t;
    logic [3:0]  exp_sel;
    logic        exp_we;
    int          last_k;
    logic [31:0] other;
    t       = $sformatf("v%0d", idx);
    exp_sel = v.is_mem ? v.sel : 4'hF;
    exp_we  = v.is_mem ? v.we : 1'b0;
    other   = v.is_mem ? if_model : mem_model;
    if (v.is_mem) begin
      ifc.mem_ce_i = 1'b1; ifc.mem_we_i = v.we; ifc.mem_addr_i = v.addr;
      ifc.mem_sel_i = v.sel; ifc.mem_data_i = v.wdata;
      mem_q.push_back(v.exp_data);
    end else begin
      ifc.if_ce_i = 1'b1; ifc.if_addr_i = v.addr;
      if_q.push_back(v.exp_data);
    end
    neg();
    chk1({t, "_req_stallreq"}, sr_of(v.is_mem), 1'b1);
    chk1({t, "_req_no_stb"}, ifc.bus_stb_o, 1'b0);
    pos();
    last_k = (v.ack_k == 0) ? int'(TO) : v.ack_k;
    for (int k = 1; k <= last_k; k++) begin
      ifc.bus_ack_i  = (k == v.ack_k);
      ifc.bus_data_i = (k == v.ack_k) ? v.rdata : GARBAGE;
      neg();
      chk1 ({t, "_busy_stb"}, ifc.bus_stb_o, 1'b1);
      chk32({t, "_busy_addr"}, ifc.bus_addr_o, v.addr);
      chk32({t, "_busy_sel"}, {28'd0, ifc.bus_sel_o}, {28'd0, exp_sel});
      chk1 ({t, "_busy_we"}, ifc.bus_we_o, exp_we);
      if (v.is_mem) chk32({t, "_busy_wdata"}, ifc.bus_data_o, v.wdata);
      chk1 ({t, "_busy_err"}, ifc.bus_err_o, v.exp_err && (k == int'(TO)));
      chk1 ({t, "_busy_stallreq"}, sr_of(v.is_mem), 1'b1);
      pos();
    end
    ifc.bus_ack_i  = 1'b0;
    ifc.bus_data_i = GARBAGE;
    for (int d = 0; d <= v.stall_cyc; d++) begin
      set_stall(v.is_mem, d < v.stall_cyc);
      neg();
      chk1 ({t, "_done_stallreq"}, sr_of(v.is_mem), 1'b0);
      chk1 ({t, "_done_stb"}, ifc.bus_stb_o, 1'b0);
      chk1 ({t, "_done_we"}, ifc.bus_we_o, 1'b0);
      chk1 ({t, "_done_err"}, ifc.bus_err_o, 1'b0);
      chk32({t, "_done_data"}, data_of(v.is_mem), v.exp_data);
      chk32({t, "_other_port_data"}, data_of(!v.is_mem), other);
      pos();
    end
    neg();
    chk1({t, "_exit_stallreq"}, sr_of(v.is_mem), 1'b1);
    chk1({t, "_exit_stb"}, ifc.bus_stb_o, 1'b0);
    #1;
    ifc.if_ce_i  = 1'b0;
    ifc.mem_ce_i = 1'b0;
    ifc.mem_we_i = 1'b0;
    pos();
    if (v.is_mem) mem_model = v.exp_data;
    else          if_model  = v.exp_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=time-limit required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            mem we addr          sel   wdata         ack rdata         stl exp           err
    vecs[0] = mk(0, 0, 32'h0000_0100, 4'h0, 32'h0,        1, 32'h3C01_1234, 0, 32'h3C01_1234, 0);
    vecs[1] = mk(1, 0, 32'h0000_0200, 4'hF, 32'h0,        2, 32'h1122_3344, 0, 32'h1122_3344, 0);
    vecs[2] = mk(1, 1, 32'h0000_0203, 4'h1, 32'h0000_00AB, 3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0);
    vecs[3] = mk(1, 0, 32'h0000_0300, 4'hF, 32'h0,        1, 32'h8BAD_F00D, 3, 32'h8BAD_F00D, 0);
    vecs[4] = mk(1, 0, 32'h0000_0304, 4'hF, 32'h0,        0, 32'h0,         1, 32'h0,         1);
    vecs[5] = mk(0, 0, 32'h0000_0104, 4'h0, 32'h0,        4, 32'h27BD_FFE8, 2, 32'h27BD_FFE8, 0);
    vecs[6] = mk(0, 0, 32'h0000_0108, 4'h0, 32'h0,        0, 32'h0,         0, 32'h0,         1);
    vecs[7] = mk(1, 1, 32'h0000_0204, 4'h3, 32'h1234_BEEF, 2, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A, 0);

    clear_inputs();
    rst = 1'b1;
    repeat (3) pos();
    neg();
    chk1 ("rst_stb", ifc.bus_stb_o, 1'b0);
    chk1 ("rst_we", ifc.bus_we_o, 1'b0);
    chk1 ("rst_err", ifc.bus_err_o, 1'b0);
    chk32("rst_addr", ifc.bus_addr_o, 32'h0);
    chk32("rst_bus_data", ifc.bus_data_o, 32'h0);
    chk32("rst_sel", {28'd0, ifc.bus_sel_o}, 32'h0);
    chk32("rst_if_data", ifc.if_data_o, 32'h0);
    chk32("rst_mem_data", ifc.mem_data_o, 32'h0);
    #1 rst = 1'b0;
    pos();

    for (int i = 0; i < 8; i++) do_access(i, vecs[i]);

    // Simultaneous load and fetch: data port first, fetch after DONE_MEM exits.
    ifc.mem_ce_i = 1'b1; ifc.mem_we_i = 1'b0; ifc.mem_addr_i = 32'h0000_0200; ifc.mem_sel_i = 4'hF;
    ifc.if_ce_i = 1'b1;  ifc.if_addr_i = 32'h0000_0104;
    mem_q.push_back(32'h600D_0001);
    if_q.push_back(32'h600D_0002);
    neg();
    chk1("sim_req_if_sr", ifc.if_stallreq_o, 1'b1);
    chk1("sim_req_mem_sr", ifc.mem_stallreq_o, 1'b1);
    pos();
    ifc.bus_ack_i = 1'b1; ifc.bus_data_i = 32'h600D_0001;
    neg();
    chk32("sim_first_addr", ifc.bus_addr_o, 32'h0000_0200);
    chk1 ("sim_first_stb", ifc.bus_stb_o, 1'b1);
    chk1 ("sim_if_waits", ifc.if_stallreq_o, 1'b1);
    pos();
    ifc.bus_ack_i = 1'b0; ifc.bus_data_i = GARBAGE;
    neg();
    chk1("sim_mem_done_sr", ifc.mem_stallreq_o, 1'b0);
    chk1("sim_if_still_sr", ifc.if_stallreq_o, 1'b1);
    chk1("sim_mem_done_stb", ifc.bus_stb_o, 1'b0);
    #1 ifc.mem_ce_i = 1'b0;
    pos();
    neg();
    chk1("sim_gap_stb", ifc.bus_stb_o, 1'b0);
    chk1("sim_gap_if_sr", ifc.if_stallreq_o, 1'b1);
    pos();
    ifc.bus_ack_i = 1'b1; ifc.bus_data_i = 32'h600D_0002;
    neg();
    chk32("sim_second_addr", ifc.bus_addr_o, 32'h0000_0104);
    chk1 ("sim_second_stb", ifc.bus_stb_o, 1'b1);
    chk32("sim_second_sel", {28'd0, ifc.bus_sel_o}, 32'hF);
    chk1 ("sim_second_we", ifc.bus_we_o, 1'b0);
    pos();
    ifc.bus_ack_i = 1'b0; ifc.bus_data_i = GARBAGE;
    neg();
    chk1 ("sim_if_done_sr", ifc.if_stallreq_o, 1'b0);
    chk32("sim_mem_data_kept", ifc.mem_data_o, 32'h600D_0001);
    #1 ifc.if_ce_i = 1'b0;
    pos();
    mem_model = 32'h600D_0001;
    if_model  = 32'h600D_0002;

    // Reset in the middle of a fetch, then a late ack that must be ignored.
    ifc.if_ce_i = 1'b1; ifc.if_addr_i = 32'h0000_0400;
    neg();
    chk1("rb_req_sr", ifc.if_stallreq_o, 1'b1);
    pos();
    neg();
    chk1 ("rb_busy_stb", ifc.bus_stb_o, 1'b1);
    chk32("rb_busy_addr", ifc.bus_addr_o, 32'h0000_0400);
    #1 rst = 1'b1; ifc.if_ce_i = 1'b0;
    pos();
    rst = 1'b0; ifc.bus_ack_i = 1'b1; ifc.bus_data_i = 32'hFFFF_FFFF;
    neg();
    chk1 ("rb_stb", ifc.bus_stb_o, 1'b0);
    chk1 ("rb_we", ifc.bus_we_o, 1'b0);
    chk1 ("rb_err", ifc.bus_err_o, 1'b0);
    chk32("rb_addr", ifc.bus_addr_o, 32'h0);
    chk32("rb_sel", {28'd0, ifc.bus_sel_o}, 32'h0);
    chk32("rb_if_data", ifc.if_data_o, 32'h0);
    chk32("rb_mem_data", ifc.mem_data_o, 32'h0);
    pos();
    ifc.bus_ack_i = 1'b0; ifc.bus_data_i = GARBAGE;
    neg();
    chk1 ("rb_late_ack_stb", ifc.bus_stb_o, 1'b0);
    chk32("rb_late_ack_if_data", ifc.if_data_o, 32'h0);
    pos();
    if_model  = '0;
    mem_model = '0;
    do_access(8, mk(0, 0, 32'h0000_010C, 4'h0, 32'h0, 1, 32'h8FBF_0010, 0, 32'h8FBF_0010, 0));

    chk32("sb_if_drained", 32'(if_q.size()), 32'h0);
    chk32("sb_mem_drained", 32'(mem_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
